// File: rtl/gray_code_pipe_converter.sv
// Pipelined bidirectional Gray/binary converter with per-word mode.
// The Gray->binary MSB-to-LSB XOR ripple is split into STAGES registered
// slices of WIDTH/STAGES bits. A carry register hands each slice's last
// resolved bit to the next stage. Binary->Gray is done entirely in stage 1
// and then rides the pipeline, so both modes have latency STAGES.
// A single global stall (advance) holds every stage under backpressure.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   in_mode             0 = Gray->binary, 1 = binary->Gray
//   in_data[WIDTH]      word to convert
//   out_valid/out_ready output handshake
//   out_mode            mode carried with the result
//   out_data[WIDTH]     converted word
module gray_code_pipe_converter #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_data
);

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("gray_code_pipe_converter: illegal WIDTH/STAGES combination");
    end

    localparam int unsigned CHUNK = WIDTH / STAGES;

    logic                          advance;
    logic [STAGES-1:0]             stg_valid;
    logic [STAGES-1:0]             stg_mode;
    logic [STAGES-1:0]             stg_carry;
    logic [STAGES-1:0][WIDTH-1:0]  stg_data;
    logic [STAGES-1:0]             nxt_valid;
    logic [STAGES-1:0]             nxt_mode;
    logic [STAGES-1:0]             nxt_carry;
    logic [STAGES-1:0][WIDTH-1:0]  nxt_data;

    // Global stall: every stage moves only when the output slot frees up.
    assign advance  = !stg_valid[STAGES-1] || out_ready;
    assign in_ready = advance;

    // Next-state of every stage, walking from the input toward the output.
    always_comb begin
        logic [WIDTH-1:0] cur_data;
        logic [WIDTH-1:0] mask;
        logic [WIDTH-1:0] pfx;
        logic [WIDTH-1:0] res;
        logic             cur_valid;
        logic             cur_mode;
        logic             cur_carry;
        int               lo;

        nxt_valid = '0;
        nxt_mode  = '0;
        nxt_carry = '0;
        nxt_data  = '0;
        cur_data  = in_data;
        cur_valid = in_valid;
        cur_mode  = in_mode;
        cur_carry = 1'b0;
        mask      = '0;
        pfx       = '0;
        res       = '0;
        lo        = 0;

        for (int k = 0; k < int'(STAGES); k++) begin
            lo   = int'(WIDTH) - (k + 1) * int'(CHUNK);
            mask = WIDTH'({CHUNK{1'b1}}) << lo;

            // Suffix XOR inside the slice (bits above it are masked to 0),
            // then fold in the carry from the previous slice.
            pfx = cur_data & mask;
            for (int sh = 1; sh < int'(WIDTH); sh = sh * 2) begin
                pfx = pfx ^ (pfx >> sh);
            end
            res = (pfx ^ {WIDTH{cur_carry}}) & mask;

            nxt_valid[k] = cur_valid;
            nxt_mode[k]  = cur_mode;
            if (cur_mode) begin
                nxt_data[k]  = (k == 0) ? (cur_data ^ (cur_data >> 1)) : cur_data;
                nxt_carry[k] = 1'b0;
            end else begin
                nxt_data[k]  = (cur_data & ~mask) | res;
                nxt_carry[k] = 1'(res >> lo);
            end

            cur_data  = stg_data[k];
            cur_valid = stg_valid[k];
            cur_mode  = stg_mode[k];
            cur_carry = stg_carry[k];
        end
    end

    // Stage registers; all hold together while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid <= '0;
            stg_mode  <= '0;
            stg_carry <= '0;
            stg_data  <= '0;
        end else if (advance) begin
            stg_valid <= nxt_valid;
            stg_mode  <= nxt_mode;
            stg_carry <= nxt_carry;
            stg_data  <= nxt_data;
        end
    end

    assign out_valid = stg_valid[STAGES-1];
    assign out_mode  = stg_mode[STAGES-1];
    assign out_data  = stg_data[STAGES-1];

endmodule

// File: tb/tb_gray_code_pipe_converter.sv
// Directed bench for gray_code_pipe_converter: four 8-bit instances
// (STAGES 1, 2, 4, 8) and one 16-bit/4-stage instance share handshake inputs.
module tb_gray_code_pipe_converter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_mode;
    logic [7:0]  in_data;
    logic [15:0] in_data16;
    logic        out_ready;

    logic        ir [4];
    logic        ov [4];
    logic        om [4];
    logic [7:0]  od [4];
    logic        ir16, ov16, om16;
    logic [15:0] od16;

    int n_cmp;
    int n_bad;
    int lat [4] = '{1, 2, 4, 8};

    gray_code_pipe_converter #(.WIDTH(8), .STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_mode(in_mode),
        .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_mode(om[0]), .out_data(od[0]));
    gray_code_pipe_converter #(.WIDTH(8), .STAGES(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_mode(in_mode),
        .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_mode(om[1]), .out_data(od[1]));
    gray_code_pipe_converter #(.WIDTH(8), .STAGES(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_mode(in_mode),
        .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_mode(om[2]), .out_data(od[2]));
    gray_code_pipe_converter #(.WIDTH(8), .STAGES(8)) u_s8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]), .in_mode(in_mode),
        .in_data(in_data), .out_valid(ov[3]), .out_ready(out_ready), .out_mode(om[3]), .out_data(od[3]));
    gray_code_pipe_converter #(.WIDTH(16), .STAGES(4)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16), .in_mode(in_mode),
        .in_data(in_data16), .out_valid(ov16), .out_ready(out_ready), .out_mode(om16), .out_data(od16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) tick();
    endtask

    function automatic logic [7:0] to_gray(int v);
        logic [7:0] b;
        b = 8'(v);
        return b ^ (b >> 1);
    endfunction

    task automatic test_reset();
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_data   = 8'h00;
        in_data16 = 16'h0000;
        out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (ov[i] !== 1'b0 || od[i] !== 8'h00 || om[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_out[%0d]: got v=%b d=%h m=%b expected 0/00/0", i, ov[i], od[i], om[i]);
            end
            n_cmp++;
            if (ir[i] !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_in_ready[%0d]: got %b expected 1", i, ir[i]);
            end
        end
        n_cmp++;
        if (ov16 !== 1'b0 || od16 !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_w16: got v=%b d=%h expected 0/0000", ov16, od16);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        drain();
        in_valid = 1'b1; in_mode = 1'b0; in_data = 8'h80;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (ov[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_early: got out_valid=%b expected 0", ov[1]);
        end
        n_cmp++;
        if (ov[0] !== 1'b1 || od[0] !== 8'hFF || om[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_s1: got v=%b d=%h m=%b expected 1/ff/0", ov[0], od[0], om[0]);
        end
        tick();
        n_cmp++;
        if (ov[1] !== 1'b1 || od[1] !== 8'hFF || om[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_s2: got v=%b d=%h m=%b expected 1/ff/0", ov[1], od[1], om[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] din  [3] = '{8'h05, 8'h07, 8'hFF};
        logic       mdin [3] = '{1'b1, 1'b0, 1'b1};
        logic [7:0] dexp [3] = '{8'h07, 8'h05, 8'h80};
        drain();
        for (int t = 0; t < 6; t++) begin
            if (t < 3) begin
                in_valid = 1'b1; in_mode = mdin[t]; in_data = din[t];
            end else begin
                in_valid = 1'b0;
            end
            if (t >= 2 && t < 5) begin
                n_cmp++;
                if (ov[1] !== 1'b1 || od[1] !== dexp[t-2] || om[1] !== mdin[t-2]) begin
                    n_bad++;
                    $display("FAIL b2b[%0d]: got v=%b d=%h m=%b expected 1/%h/%b",
                             t - 2, ov[1], od[1], om[1], dexp[t-2], mdin[t-2]);
                end
            end else if (t == 5) begin
                n_cmp++;
                if (ov[1] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_tail: got out_valid=%b expected 0", ov[1]);
                end
            end
            tick();
        end
    endtask

    task automatic test_wide();
        drain();
        in_data = 8'h00;
        for (int t = 0; t < 7; t++) begin
            in_mode = 1'b0;
            if (t == 0) begin
                in_valid = 1'b1; in_data16 = 16'h8000;
            end else if (t == 1) begin
                in_valid = 1'b1; in_data16 = 16'h0000;
            end else begin
                in_valid = 1'b0;
            end
            n_cmp++;
            if (t == 4) begin
                if (ov16 !== 1'b1 || od16 !== 16'hFFFF || om16 !== 1'b0) begin
                    n_bad++;
                    $display("FAIL wide_first: got v=%b d=%h expected 1/ffff", ov16, od16);
                end
            end else if (t == 5) begin
                if (ov16 !== 1'b1 || od16 !== 16'h0000 || om16 !== 1'b0) begin
                    n_bad++;
                    $display("FAIL wide_second: got v=%b d=%h expected 1/0000", ov16, od16);
                end
            end else if (ov16 !== 1'b0) begin
                n_bad++;
                $display("FAIL wide_idle[%0d]: got out_valid=%b expected 0", t, ov16);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] got [$];
        logic [7:0] exp_q [6] = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05};
        logic       stall;
        int         idx;
        drain();
        idx = 0;
        for (int c = 0; c < 14; c++) begin
            stall     = (c >= 3 && c <= 6);
            out_ready = !stall;
            in_valid  = (idx < 6);
            in_mode   = 1'b1;
            in_data   = 8'(idx + 1);
            #1;
            n_cmp++;
            if (ir[1] !== !stall) begin
                n_bad++;
                $display("FAIL bp_in_ready[%0d]: got %b expected %b", c, ir[1], !stall);
            end
            if (stall) begin
                n_cmp++;
                if (ov[1] !== 1'b1 || od[1] !== 8'h03) begin
                    n_bad++;
                    $display("FAIL bp_hold[%0d]: got v=%b d=%h expected 1/03", c, ov[1], od[1]);
                end
            end
            if (ov[1] === 1'b1 && out_ready) got.push_back(od[1]);
            if (in_valid && ir[1] === 1'b1) idx++;
            tick();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        n_cmp++;
        if (got.size() != 6) begin
            n_bad++;
            $display("FAIL bp_count: got %0d results expected 6", got.size());
        end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL bp_order[%0d]: got %h expected %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        drain();
        for (int t = 0; t < 3; t++) begin
            in_valid = 1'b1; in_mode = 1'b1; in_data = 8'(8'h11 * (t + 1));
            tick();
        end
        in_valid = 1'b0;
        n_cmp++;
        if (ov[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL rmid_inflight: got out_valid=%b expected 1", ov[1]);
        end
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (ov[i] !== 1'b0 || od[i] !== 8'h00) begin
                n_bad++;
                $display("FAIL rmid_clear[%0d]: got v=%b d=%h expected 0/00", i, ov[i], od[i]);
            end
        end
        rst_n = 1'b1;
        for (int t = 0; t < 12; t++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (ov[i] !== 1'b0 || ir[i] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL rmid_after[%0d][%0d]: got v=%b rdy=%b expected 0/1", t, i, ov[i], ir[i]);
                end
            end
        end
    endtask

    task automatic test_roundtrip();
        int         idx;
        logic [7:0] dexp;
        logic       mexp;
        drain();
        for (int t = 0; t < 521; t++) begin
            for (int i = 0; i < 4; i++) begin
                idx = t - lat[i];
                n_cmp++;
                if (idx >= 0 && idx < 512) begin
                    dexp = (idx < 256) ? to_gray(idx) : 8'(idx - 256);
                    mexp = (idx < 256);
                    if (ov[i] !== 1'b1 || od[i] !== dexp || om[i] !== mexp) begin
                        n_bad++;
                        $display("FAIL roundtrip[S=%0d][%0d]: got v=%b d=%h m=%b expected 1/%h/%b",
                                 lat[i], idx, ov[i], od[i], om[i], dexp, mexp);
                    end
                end else if (ov[i] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL roundtrip_idle[S=%0d][%0d]: got out_valid=%b expected 0", lat[i], t, ov[i]);
                end
            end
            if (t < 256) begin
                in_valid = 1'b1; in_mode = 1'b1; in_data = 8'(t);
            end else if (t < 512) begin
                in_valid = 1'b1; in_mode = 1'b0; in_data = to_gray(t - 256);
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_wide();
        test_backpressure();
        test_reset_mid();
        test_roundtrip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gray_code_pipe_converter.md
Name: gray_code_pipe_converter

Overview:
Parametrised, pipelined bidirectional Gray/binary converter with a per-transaction mode bit. It replaces fixed 8-bit combinational converters where wide words make the MSB-to-LSB XOR ripple timing-critical. The ripple is split into STAGES registered slices. A valid/ready handshake with full backpressure allows the block to sit between streaming producers and consumers, for example counter-sampling and CDC pointer paths.

Parameters:
WIDTH, 8, data width in bits; must be >= 2.
STAGES, 2, pipeline depth and number of bit slices; 1 <= STAGES <= WIDTH, WIDTH % STAGES == 0; violation is an elaboration error.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word present
in_ready  output  1  block accepts input this cycle
in_mode  input  1  0 = Gray->binary, 1 = binary->Gray
in_data  input  WIDTH  word to convert
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
out_mode  output  1  mode carried with the result
out_data  output  WIDTH  converted word

Behaviour:
- Reset: `rst_n` low asynchronously clears all stage valid bits, `out_valid`, `out_mode` and `out_data` to 0, and every internal data/carry register to 0. The block leaves reset on the first rising `clk` edge after `rst_n` goes high.
- Global stall rule: `advance = !out_valid || out_ready`.
  - `in_ready = advance`, purely combinational. It has no dependence on `in_valid`.
  - A word is accepted when `in_valid && in_ready`.
  - When `advance` is 0, every stage register holds its value.
- Pipeline:
  - STAGES register stages; stage STAGES drives the outputs directly.
  - An accepted word appears on `out_*` exactly STAGES cycles after acceptance when there is no stall. Each stall cycle adds one cycle.
  - Throughput is one word per cycle when `out_ready` is held high.
  - Bubbles (accept cycles with `in_valid` = 0) propagate as valid = 0 stages. Data in invalid stages is don't-care but must not glitch `out_data` while `out_valid` = 1.
- Slice split: `CHUNK = WIDTH/STAGES`. Stage k (1..STAGES) resolves output bits `[WIDTH-1-(k-1)*CHUNK : WIDTH-k*CHUNK]`.
- Gray->binary (mode 0):
  - `b[WIDTH-1] = g[WIDTH-1]`; `b[i] = b[i+1] ^ g[i]`.
  - Stage k starts from the last resolved bit of stage k-1, carried in a registered carry bit. Stage 1 uses carry 0.
  - Unresolved Gray bits travel with the word through the pipeline.
- Binary->Gray (mode 1):
  - `g[i] = b[i] ^ b[i+1]`; `g[WIDTH-1] = b[WIDTH-1]`.
  - Computed fully in stage 1, then passed unchanged through the remaining stages. Latency is identical to mode 0.
- Mode is carried per word. Mixed-mode back-to-back words are legal, and each word converts according to its own mode.
- STAGES = 1: single register stage; latency 1.
- While `out_valid` = 1 and `out_ready` = 0, `out_valid`, `out_mode` and `out_data` stay stable until the handshake completes.
- Reset asserted mid-stream discards all in-flight words. No partial result is emitted after release.

Test Plan:
- WIDTH=8, STAGES=2, `out_ready`=1; send mode 0, `in_data` = 8'h80 -> after 2 cycles `out_valid` = 1, `out_data` = 8'hFF, `out_mode` = 0.
- WIDTH=8, STAGES=2; back-to-back mode 1 8'h05 then mode 0 8'h07 then mode 1 8'hFF -> outputs on consecutive cycles: 8'h07 (mode 1), 8'h05 (mode 0), 8'h80 (mode 1).
- WIDTH=16, STAGES=4; mode 0 16'h8000 -> 16'hFFFF after 4 cycles. Then mode 0 16'h0000 -> 16'h0000 on the next cycle.
- Backpressure: stream 8'h01..8'h06 (mode 1) with `out_ready` low for cycles 3-6 of the stream:
  - `in_ready` drops the same cycle `out_valid` && !`out_ready`.
  - `out_data` holds steady throughout the stall.
  - All six results arrive in order with none lost or duplicated: 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05.
- Reset mid-operation: 3 words in flight, pulse `rst_n` low for 1 ns between edges -> `out_valid` = 0 and `out_data` = 0 immediately; no in-flight word ever emerges; `in_ready` = 1 after release.
- Exhaustive round-trip: WIDTH=8, STAGES in {1, 2, 4, 8}; all 256 values through mode 1, then the result through mode 0 -> original value recovered; latency equals STAGES.
